// File: rtl/wide_alu_pkg.sv
// -----------------------------------------------------------------------------
// wide_alu_pkg
//
// Purpose: shared types and helpers for the wide_alu block.
//   - op_e     : 3-bit opcode encodings
//   - state_e  : control FSM states (idle / multiply in flight)
//   - is_reserved() : opcode legality check; it follows the optional
//                     subtract feature selected by the WIDE_ALU_SUB_EN macro
//   - cnt_bits()    : width of the multiply down-counter
//
// Configuration macro: WIDE_ALU_SUB_EN (when defined, opcode 101 is subtract;
// otherwise it is reserved).
// -----------------------------------------------------------------------------
package wide_alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_MUL = 3'b100,
    OP_SUB = 3'b101
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // Returns 1 for any opcode the current build does not implement.
  function automatic logic is_reserved(input logic [OP_W-1:0] code);
    logic rsv;
    case (code)
      OP_NOP, OP_ADD, OP_AND, OP_XOR, OP_MUL: rsv = 1'b0;
`ifdef WIDE_ALU_SUB_EN
      OP_SUB:                                 rsv = 1'b0;
`endif
      default:                                rsv = 1'b1;
    endcase
    return rsv;
  endfunction

  // Bits needed to hold the value cycles-1 (cycles is at least 2).
  function automatic int cnt_bits(input int cycles);
    int w;
    w = $clog2(cycles);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/wide_alu_mul.sv
// -----------------------------------------------------------------------------
// wide_alu_mul
//
// Purpose: multi-cycle unsigned multiplier used by wide_alu. Operands are
// latched on start, a down-counter times the operation, and the product is
// held in a register so the multiplier array has a full clock (or more) to
// settle before the top level samples it.
//
// Parameters:
//   WIDTH      operand width
//   MUL_CYCLES clocks from the start edge to the edge at which the top level
//              registers the product
//
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset
//   start    in   load operands and begin a multiply (ignored by the caller
//                 unless the unit is free or finishing)
//   a, b     in   operands, sampled only when start is high
//   done     out  high during the last cycle of a multiply; product is valid
//                 and the caller registers it at the next rising edge
//   product  out  registered 2*WIDTH unsigned product
// -----------------------------------------------------------------------------
module wide_alu_mul
  import wide_alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = cnt_bits(MUL_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_CYCLES - 1);

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CW-1:0]    cnt_reg;
  logic             run_reg;
  logic [RW-1:0]    product_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg       <= '0;
      b_reg       <= '0;
      cnt_reg     <= '0;
      run_reg     <= 1'b0;
      product_reg <= '0;
    end else begin
      if (start) begin
        a_reg   <= a;
        b_reg   <= b;
        cnt_reg <= CNT_LOAD;
        run_reg <= 1'b1;
      end else if (run_reg) begin
        if (cnt_reg == '0) begin
          run_reg <= 1'b0;
        end else begin
          cnt_reg <= cnt_reg - 1'b1;
        end
      end
      // Recomputed every running cycle from the latched operands; it is
      // stable from the first edge after start, long before done.
      if (run_reg) begin
        product_reg <= RW'(a_reg) * RW'(b_reg);
      end
    end
  end

  assign done    = run_reg && (cnt_reg == '0);
  assign product = product_reg;

endmodule

// File: rtl/wide_alu.sv
// -----------------------------------------------------------------------------
// wide_alu
//
// Purpose: parametrised ALU with a start/done handshake. add/and/xor (and
// optionally sub) complete in one clock; mul runs in wide_alu_mul for
// MUL_CYCLES clocks while busy blocks new requests. All results are
// zero-extended to 2*WIDTH bits.
//
// Configuration macro: WIDE_ALU_SUB_EN -- when defined, opcode 101 is a
// single-cycle subtract (2*WIDTH two's complement of A-B); otherwise 101 is
// reserved and reports err.
//
// Parameters:
//   WIDTH      operand width (>= 2)
//   MUL_CYCLES multiply latency, start edge to done edge (>= 2)
//
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   A, B     in   operands, sampled on an accepted start
//   op       in   opcode, sampled on an accepted start
//   start    in   request; accepted when high at a rising edge with busy low
//   done     out  one-cycle completion pulse per accepted request
//   result   out  2*WIDTH result, held between completions
//   busy     out  high while a multiply is in flight
//   err      out  pulses with done when the accepted opcode was reserved
// -----------------------------------------------------------------------------
module wide_alu
  import wide_alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [OP_W-1:0]    op,
  input  logic               start,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               err
);

  localparam int RW = 2 * WIDTH;

  state_e          state_reg;
  logic            done_reg;
  logic            err_reg;
  logic [RW-1:0]   result_reg;

  // One-deep holding slot for a single-cycle result whose completion edge is
  // already taken by a finishing multiply (see output stage below).
  logic            pend_valid_reg;
  logic            pend_err_reg;
  logic            pend_keep_reg;
  logic [RW-1:0]   pend_result_reg;

  logic            mul_done;
  logic [RW-1:0]   mul_product;
  logic            mul_last;
  logic            accept;
  logic            mul_start;
  logic            sc_valid;
  logic [RW-1:0]   sc_result;
  logic            sc_err;
  logic            sc_keep;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // busy drops in the final multiply cycle so a new request can be accepted on
  // the same edge that retires the product.
  assign mul_last  = (state_reg == ST_MUL) && mul_done;
  assign busy      = (state_reg == ST_MUL) && !mul_done;
  assign accept    = start && !busy;
  assign mul_start = accept && (op == OP_MUL);
  assign sc_valid  = accept && (op != OP_MUL);

  // ---------------------------------------------------------------------------
  // Multiplier
  // ---------------------------------------------------------------------------
  wide_alu_mul #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (A),
    .b       (B),
    .done    (mul_done),
    .product (mul_product)
  );

  // ---------------------------------------------------------------------------
  // Single-cycle datapath, evaluated on the live operands
  // ---------------------------------------------------------------------------
  always_comb begin
    sc_result = '0;
    sc_err    = 1'b0;
    sc_keep   = 1'b0;
    if (is_reserved(op)) begin
      sc_err = 1'b1;
    end else begin
      case (op)
        OP_NOP: sc_keep   = 1'b1;
        OP_ADD: sc_result = RW'(A) + RW'(B);
        OP_AND: sc_result = RW'(A & B);
        OP_XOR: sc_result = RW'(A ^ B);
`ifdef WIDE_ALU_SUB_EN
        OP_SUB: sc_result = RW'(A) - RW'(B);
`endif
        default: sc_result = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and output register
  // ---------------------------------------------------------------------------
  // A single-cycle request accepted on the edge that retires a multiply cannot
  // share that completion: the product is reported first and the single-cycle
  // result follows one edge later from the holding slot. While the slot is
  // occupied, newly accepted single-cycle requests queue behind it in order,
  // so done stays high and no completion is lost; the slot drains on the first
  // edge without a new single-cycle request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_IDLE;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      result_reg      <= '0;
      pend_valid_reg  <= 1'b0;
      pend_err_reg    <= 1'b0;
      pend_keep_reg   <= 1'b0;
      pend_result_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (mul_start) state_reg <= ST_MUL;
        end
        ST_MUL: begin
          if (mul_done) state_reg <= mul_start ? ST_MUL : ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase

      done_reg <= 1'b0;
      err_reg  <= 1'b0;

      if (mul_last) begin
        done_reg        <= 1'b1;
        result_reg      <= mul_product;
        pend_valid_reg  <= sc_valid;
        pend_err_reg    <= sc_err;
        pend_keep_reg   <= sc_keep;
        pend_result_reg <= sc_result;
      end else if (pend_valid_reg) begin
        done_reg        <= 1'b1;
        err_reg         <= pend_err_reg;
        if (!pend_keep_reg) result_reg <= pend_result_reg;
        pend_valid_reg  <= sc_valid;
        pend_err_reg    <= sc_err;
        pend_keep_reg   <= sc_keep;
        pend_result_reg <= sc_result;
      end else if (sc_valid) begin
        done_reg <= 1'b1;
        err_reg  <= sc_err;
        // no_op leaves result untouched; reserved opcodes load zero.
        if (!sc_keep) result_reg <= sc_result;
      end
    end
  end

  assign done   = done_reg;
  assign err    = err_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_wide_alu.sv
// -----------------------------------------------------------------------------
// tb_wide_alu
//
// Directed bench for wide_alu (WIDTH=8, MUL_CYCLES=3). Inputs change and
// outputs are sampled 1 time unit after each rising edge. Follows the
// WIDE_ALU_SUB_EN macro for the opcode-101 expectations.
// -----------------------------------------------------------------------------
module tb_wide_alu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [2:0]  op;
  logic        start;
  logic        done;
  logic [15:0] result;
  logic        busy;
  logic        err;

  int total = 0;
  int bad   = 0;

  wide_alu #(
    .WIDTH      (8),
    .MUL_CYCLES (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .A       (a),
    .B       (b),
    .op      (op),
    .start   (start),
    .done    (done),
    .result  (result),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic txn(input string name);
    $display("txn %-8s A=%h B=%h op=%b -> done=%b result=%h err=%b busy=%b",
             name, a, b, op, done, result, err, busy);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    op      = '0;

    // Reset state
    tick(); tick();
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_err",    32'(err),    32'd0);
    chk("rst_result", 32'(result), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_done",  32'(done),   32'd0);

    // add FF + 01 = 0100
    a = 8'hFF; b = 8'h01; op = 3'b001; start = 1'b1;
    tick(); start = 1'b0;
    txn("add");
    chk("add_done",   32'(done),   32'd1);
    chk("add_result", 32'(result), 32'h0100);
    chk("add_err",    32'(err),    32'd0);
    tick();
    chk("add_done_low", 32'(done),   32'd0);
    chk("add_hold",     32'(result), 32'h0100);

    // mul FF * FF = FE01, second start while busy is dropped
    a = 8'hFF; b = 8'hFF; op = 3'b100; start = 1'b1;
    tick();                                   // edge N
    chk("mul_busy_n",  32'(busy), 32'd1);
    chk("mul_done_n",  32'(done), 32'd0);
    a = 8'h02; b = 8'h03; op = 3'b001;        // still start=1, busy high
    tick();                                   // edge N+1
    start = 1'b0; a = 8'h11; b = 8'h22;
    chk("mul_busy_n1", 32'(busy), 32'd1);
    chk("mul_done_n1", 32'(done), 32'd0);
    tick();                                   // edge N+2
    chk("mul_busy_n2", 32'(busy), 32'd0);
    chk("mul_done_n2", 32'(done), 32'd0);
    tick();                                   // edge N+3
    txn("mul");
    chk("mul_done",    32'(done),   32'd1);
    chk("mul_result",  32'(result), 32'hFE01);
    chk("mul_err",     32'(err),    32'd0);
    chk("mul_busy_dn", 32'(busy),   32'd0);
    tick();
    chk("drop_no_done", 32'(done),   32'd0);
    chk("mul_hold",     32'(result), 32'hFE01);

    // back-to-back and/xor
    a = 8'hF0; b = 8'h3C; op = 3'b010; start = 1'b1;
    tick();
    txn("and");
    chk("and_done",   32'(done),   32'd1);
    chk("and_result", 32'(result), 32'h0030);
    op = 3'b011;
    tick();
    txn("xor");
    chk("xor_done",   32'(done),   32'd1);
    chk("xor_result", 32'(result), 32'h00CC);
    start = 1'b0;
    tick();
    chk("bb_done_low", 32'(done), 32'd0);

    // reserved opcode then no_op
    a = 8'h05; b = 8'h05; op = 3'b110; start = 1'b1;
    tick();
    txn("rsv110");
    chk("rsv_done",   32'(done),   32'd1);
    chk("rsv_err",    32'(err),    32'd1);
    chk("rsv_result", 32'(result), 32'h0000);
    op = 3'b000;
    tick();
    txn("nop");
    chk("nop_done",   32'(done),   32'd1);
    chk("nop_err",    32'(err),    32'd0);
    chk("nop_result", 32'(result), 32'h0000);
    start = 1'b0;
    tick();
    chk("nop_done_low", 32'(done), 32'd0);

    // start held high on mul: re-issued on the edge where busy is low
    a = 8'h03; b = 8'h05; op = 3'b100; start = 1'b1;
    tick();                                   // N: accepted
    tick();                                   // N+1: dropped
    tick();                                   // N+2: dropped
    chk("held_done_n2", 32'(done), 32'd0);
    tick();                                   // N+3: done + new mul accepted
    start = 1'b0;
    txn("mul_held");
    chk("held_done1",   32'(done),   32'd1);
    chk("held_result1", 32'(result), 32'h000F);
    chk("held_busy",    32'(busy),   32'd1);
    tick(); tick();
    chk("held_gap",     32'(done),   32'd0);
    tick();                                   // N+6
    txn("mul_held");
    chk("held_done2",   32'(done),   32'd1);
    chk("held_result2", 32'(result), 32'h000F);
    tick();
    chk("held_done_low", 32'(done),  32'd0);

    // nonzero result before the reset test
    a = 8'h7F; b = 8'h01; op = 3'b001; start = 1'b1;
    tick(); start = 1'b0;
    txn("add");
    chk("pre_rst_result", 32'(result), 32'h0080);

    // reset mid-multiply
    a = 8'hFF; b = 8'hFF; op = 3'b100; start = 1'b1;
    tick(); start = 1'b0;
    chk("rm_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rm_result", 32'(result), 32'd0);
    chk("rm_busy0",  32'(busy),   32'd0);
    chk("rm_done0",  32'(done),   32'd0);
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rm_no_done", 32'(done), 32'd0);
    end
    chk("rm_result_after", 32'(result), 32'd0);

    // fresh add after reset
    a = 8'h12; b = 8'h34; op = 3'b001; start = 1'b1;
    tick(); start = 1'b0;
    txn("add");
    chk("fresh_done",   32'(done),   32'd1);
    chk("fresh_result", 32'(result), 32'h0046);

    // opcode 101: sub when enabled, reserved otherwise
    a = 8'h01; b = 8'h02; op = 3'b101; start = 1'b1;
    tick(); start = 1'b0;
    txn("op101");
    chk("op101_done", 32'(done), 32'd1);
`ifdef WIDE_ALU_SUB_EN
    chk("sub_result", 32'(result), 32'hFFFF);
    chk("sub_err",    32'(err),    32'd0);
`else
    chk("op101_err",    32'(err),    32'd1);
    chk("op101_result", 32'(result), 32'h0000);
`endif
    tick();
    chk("op101_err_low", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
